// File: rtl/mp_intc_if.sv
// mp_intc_if
//   Config-register port of the mp_intc interrupt controller.
//
//   Handshake: the master raises cfg_req with cfg_rwn/cfg_adr/cfg_wdata
//   valid in the same cycle. The slave always accepts (there is no ready
//   signal). A write takes effect on that clock edge. cfg_ack is high for
//   exactly one cycle on the following cycle, and cfg_rdata is valid only
//   while cfg_ack is high (it is 0 for writes). Holding cfg_req high issues
//   one access per cycle, and each access is acked one cycle later.
//
//   Signals:
//     cfg_req    master->slave  access request
//     cfg_rwn    master->slave  1 = read, 0 = write
//     cfg_adr    master->slave  register index (3 bits)
//     cfg_wdata  master->slave  write data (32 bits)
//     cfg_ack    slave->master  one-cycle completion
//     cfg_rdata  slave->master  read data (32 bits)
interface mp_intc_if;
    logic        cfg_req;
    logic        cfg_rwn;
    logic [2:0]  cfg_adr;
    logic [31:0] cfg_wdata;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_req, cfg_rwn, cfg_adr, cfg_wdata,
        input  cfg_ack, cfg_rdata
    );

    modport slave (
        input  cfg_req, cfg_rwn, cfg_adr, cfg_wdata,
        output cfg_ack, cfg_rdata
    );
endinterface

// File: rtl/mp_intc.sv
// mp_intc
//   Machine-level interrupt controller that feeds the core's branch unit.
//   It collects NIRQ external request lines, each of which is edge or level
//   triggered. It arbitrates so that the lowest-numbered source wins, and it
//   hands the core a registered exi/exi_code pair. It also tracks the global
//   enable (mie), the cause, and the saved PC (mepc) on interrupt or ecall
//   entry.
//
//   Optional feature macro: MP_INTC_VECTORED_EN
//     defined   : mvec = MVEC + {exi_code, 2'b00} while exi is high
//     undefined : mvec = MVEC always (single shared vector)
//
//   Ports:
//     sys_clk, sys_rst  clock, synchronous active-high reset
//     irq_in[NIRQ]      external requests, already synchronous to sys_clk
//     swi               ecall pulse; unconditional entry with cause 0
//     mie_set           wfi/mret pulse; sets mie
//     pc_epc[32]        PC that is captured into mepc on entry
//     mie, exi          global enable, external interrupt request
//     exi_code[5]       winning source index + 1 (0 when exi is low)
//     mvec[32], mepc[32] vector and saved PC
//     cfg               config-register port (mp_intc_if.slave)
//
//   Register map (cfg_adr):
//     0 STATUS  bit0 mie, bits 12:8 cause
//     1 ENABLE  2 PENDING (W1C)  3 EDGE  4 MVEC (bits 1:0 read as 0)
//     5 MEPC    6 SWSET (write-1 sets edge pending, reads 0)  7 reserved
module mp_intc #(
    parameter int          NIRQ     = 8,
    parameter logic [31:0] MVEC_RST = 32'h0000_0100
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            swi,
    input  logic            mie_set,
    input  logic [31:0]     pc_epc,
    output logic            mie,
    output logic            exi,
    output logic [4:0]      exi_code,
    output logic [31:0]     mvec,
    output logic [31:0]     mepc,
    mp_intc_if.slave        cfg
);

    localparam logic [2:0] ADR_STATUS  = 3'd0;
    localparam logic [2:0] ADR_ENABLE  = 3'd1;
    localparam logic [2:0] ADR_PENDING = 3'd2;
    localparam logic [2:0] ADR_EDGE    = 3'd3;
    localparam logic [2:0] ADR_MVEC    = 3'd4;
    localparam logic [2:0] ADR_MEPC    = 3'd5;
    localparam logic [2:0] ADR_SWSET   = 3'd6;

    logic [4:0]      cause;
    logic [NIRQ-1:0] enable_r;
    logic [NIRQ-1:0] pending_r;
    logic [NIRQ-1:0] edge_mode;
    logic [NIRQ-1:0] irq_d;
    logic [31:0]     mvec_r;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pend_eff;
    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] take_clr;
    logic [NIRQ-1:0] clr_v;
    logic [NIRQ-1:0] set_v;
    logic [NIRQ-1:0] pend_nxt;
    logic [4:0]      code_nxt;
    logic [31:0]     rdata_nxt;
    logic            cfg_wr;
    logic            take;

    assign cfg_wr = cfg.cfg_req & ~cfg.cfg_rwn;
    // ecall has priority over an external take. A pending exi is held over.
    assign take   = exi & mie & ~swi;
    assign rise   = irq_in & ~irq_d;

    // Level sources bypass the pending register. This keeps their latency
    // to exi at a single cycle, and it makes W1C or a take meaningless for them.
    assign pend_eff = (pending_r & edge_mode) | (irq_in & ~edge_mode);
    assign req      = pend_eff & enable_r;

    always_comb begin
        take_clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            take_clr[i] = take && (exi_code == 5'(i + 1));
        end

        clr_v = take_clr;
        if (cfg_wr && cfg.cfg_adr == ADR_PENDING) begin
            clr_v = clr_v | cfg.cfg_wdata[NIRQ-1:0];
        end

        set_v = rise;
        if (cfg_wr && cfg.cfg_adr == ADR_SWSET) begin
            set_v = set_v | cfg.cfg_wdata[NIRQ-1:0];
        end

        // Sets are applied after clears, so an edge coincident with a clear survives.
        pend_nxt = (edge_mode & ((pending_r & ~clr_v) | set_v)) | (~edge_mode & irq_in);
    end

    // Lowest-numbered requesting source wins. The loop scans downward so the
    // last assignment is the lowest index.
    always_comb begin
        code_nxt = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                code_nxt = 5'(i + 1);
            end
        end
    end

    always_comb begin
        rdata_nxt = '0;
        if (cfg.cfg_req && cfg.cfg_rwn) begin
            case (cfg.cfg_adr)
                ADR_STATUS:  begin
                    rdata_nxt[0]    = mie;
                    rdata_nxt[12:8] = cause;
                end
                ADR_ENABLE:  rdata_nxt[NIRQ-1:0] = enable_r;
                ADR_PENDING: rdata_nxt[NIRQ-1:0] = pend_eff;
                ADR_EDGE:    rdata_nxt[NIRQ-1:0] = edge_mode;
                ADR_MVEC:    rdata_nxt = mvec_r;
                ADR_MEPC:    rdata_nxt = mepc;
                default:     rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mie           <= 1'b0;
            exi           <= 1'b0;
            exi_code      <= '0;
            cause         <= '0;
            enable_r      <= '0;
            pending_r     <= '0;
            edge_mode     <= '0;
            irq_d         <= '0;
            mepc          <= '0;
            mvec_r        <= MVEC_RST;
            cfg.cfg_ack   <= 1'b0;
            cfg.cfg_rdata <= '0;
        end else begin
            irq_d         <= irq_in;
            pending_r     <= pend_nxt;
            exi           <= |req;
            exi_code      <= code_nxt;
            cfg.cfg_ack   <= cfg.cfg_req;
            cfg.cfg_rdata <= rdata_nxt;

            if (cfg_wr) begin
                case (cfg.cfg_adr)
                    ADR_STATUS: begin
                        mie   <= cfg.cfg_wdata[0];
                        cause <= cfg.cfg_wdata[12:8];
                    end
                    ADR_ENABLE: enable_r  <= cfg.cfg_wdata[NIRQ-1:0];
                    ADR_EDGE:   edge_mode <= cfg.cfg_wdata[NIRQ-1:0];
                    ADR_MVEC:   mvec_r    <= {cfg.cfg_wdata[31:2], 2'b00};
                    ADR_MEPC:   mepc      <= cfg.cfg_wdata;
                    default:    ;
                endcase
            end

            // Entry events are placed after the config write. Because the
            // last assignment wins, they override any STATUS/MEPC write in the same cycle.
            if (swi) begin
                mepc  <= pc_epc;
                mie   <= 1'b0;
                cause <= '0;
            end else if (take) begin
                mepc  <= pc_epc;
                mie   <= 1'b0;
                cause <= exi_code;
            end else if (mie_set) begin
                mie   <= 1'b1;
            end
        end
    end

`ifdef MP_INTC_VECTORED_EN
    assign mvec = exi ? (mvec_r + {25'd0, exi_code, 2'b00}) : mvec_r;
`else
    assign mvec = mvec_r;
`endif

endmodule

// File: tb/tb_mp_intc.sv
// tb_mp_intc
//   Directed bench for mp_intc with hand-computed expectations. The bench
//   drives inputs 1 ns after each rising edge and samples outputs at the same
//   point.
module tb_mp_intc;
    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  irq_in;
    logic        swi;
    logic        mie_set;
    logic [31:0] pc_epc;
    logic        mie;
    logic        exi;
    logic [4:0]  exi_code;
    logic [31:0] mvec;
    logic [31:0] mepc;

    int n_chk;
    int n_err;

    logic [31:0] rd;
    logic [31:0] exp_vec;

    mp_intc_if cfg_bus ();

    mp_intc #(.NIRQ(8), .MVEC_RST(32'h0000_0100)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .irq_in   (irq_in),
        .swi      (swi),
        .mie_set  (mie_set),
        .pc_epc   (pc_epc),
        .mie      (mie),
        .exi      (exi),
        .exi_code (exi_code),
        .mvec     (mvec),
        .mepc     (mepc),
        .cfg      (cfg_bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_bus.cfg_req   = 1'b1;
        cfg_bus.cfg_rwn   = 1'b0;
        cfg_bus.cfg_adr   = a;
        cfg_bus.cfg_wdata = d;
        tick();
        cfg_bus.cfg_req   = 1'b0;
        chk("wr_ack", {31'd0, cfg_bus.cfg_ack}, 32'd1);
        chk("wr_rdata", cfg_bus.cfg_rdata, 32'd0);
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        cfg_bus.cfg_req   = 1'b1;
        cfg_bus.cfg_rwn   = 1'b1;
        cfg_bus.cfg_adr   = a;
        cfg_bus.cfg_wdata = 32'hDEAD_BEEF;
        tick();
        cfg_bus.cfg_req   = 1'b0;
        chk("rd_ack", {31'd0, cfg_bus.cfg_ack}, 32'd1);
        d = cfg_bus.cfg_rdata;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        sys_rst = 1'b1;
        irq_in  = '0;
        swi     = 1'b0;
        mie_set = 1'b0;
        pc_epc  = '0;
        cfg_bus.cfg_req   = 1'b0;
        cfg_bus.cfg_rwn   = 1'b1;
        cfg_bus.cfg_adr   = '0;
        cfg_bus.cfg_wdata = '0;
`ifdef MP_INTC_VECTORED_EN
        exp_vec = 32'h0000_0114;
`else
        exp_vec = 32'h0000_0100;
`endif

        // Reset values
        repeat (3) tick();
        chk("rst_mie", {31'd0, mie}, 32'd0);
        chk("rst_exi", {31'd0, exi}, 32'd0);
        chk("rst_code", {27'd0, exi_code}, 32'd0);
        chk("rst_mvec", mvec, 32'h100);
        chk("rst_mepc", mepc, 32'd0);
        chk("rst_ack", {31'd0, cfg_bus.cfg_ack}, 32'd0);
        sys_rst = 1'b0;
        tick();

        // Read every register back-to-back after reset
        for (int a = 0; a < 8; a++) begin
            cfg_read(3'(a), rd);
            chk($sformatf("rst_reg%0d", a), rd, (a == 4) ? 32'h100 : 32'h0);
        end
        tick();
        chk("idle_ack", {31'd0, cfg_bus.cfg_ack}, 32'd0);

        // Two edge sources arrive together; lowest (src 2 -> code 3) wins
        cfg_write(3'd1, 32'h0C);
        cfg_write(3'd3, 32'h0C);
        cfg_write(3'd0, 32'h1);
        chk("t1_mie_on", {31'd0, mie}, 32'd1);
        irq_in = 8'h0C;
        pc_epc = 32'h2000;
        tick();
        chk("t1_exi_lat1", {31'd0, exi}, 32'd0);
        irq_in = 8'h00;
        tick();
        chk("t1_exi", {31'd0, exi}, 32'd1);
        chk("t1_code", {27'd0, exi_code}, 32'd3);
        tick();
        chk("t1_take_mie", {31'd0, mie}, 32'd0);
        chk("t1_take_mepc", mepc, 32'h2000);
        cfg_read(3'd0, rd);
        chk("t1_status", rd, 32'h300);
        cfg_read(3'd2, rd);
        chk("t1_pending", rd, 32'h08);
        chk("t1_code4", {27'd0, exi_code}, 32'd4);

        // mie_set coincident with exi: no take now, take next cycle
        pc_epc  = 32'h3000;
        mie_set = 1'b1;
        tick();
        mie_set = 1'b0;
        pc_epc  = 32'h3004;
        chk("t5_mie_set", {31'd0, mie}, 32'd1);
        chk("t5_no_take", mepc, 32'h2000);
        tick();
        pc_epc  = 32'h0;
        chk("t5_take_mepc", mepc, 32'h3004);
        chk("t5_take_mie", {31'd0, mie}, 32'd0);
        cfg_read(3'd0, rd);
        chk("t5_status", rd, 32'h400);
        cfg_read(3'd2, rd);
        chk("t5_pending", rd, 32'h0);
        chk("t5_exi_off", {31'd0, exi}, 32'd0);

        // Level source 0: W1C and take have no effect; 1-cycle latency
        cfg_write(3'd1, 32'h01);
        cfg_write(3'd3, 32'h00);
        irq_in = 8'h01;
        tick();
        chk("t3_exi", {31'd0, exi}, 32'd1);
        chk("t3_code", {27'd0, exi_code}, 32'd1);
        cfg_write(3'd2, 32'h01);
        cfg_read(3'd2, rd);
        chk("t3_pending", rd, 32'h01);
        chk("t3_exi_held", {31'd0, exi}, 32'd1);
        irq_in = 8'h00;
        tick();
        chk("t3_exi_drop", {31'd0, exi}, 32'd0);

        // swi with exi and mie both high: ecall wins, exi stays pending
        irq_in = 8'h01;
        tick();
        cfg_write(3'd0, 32'h1);
        chk("t4_mie", {31'd0, mie}, 32'd1);
        chk("t4_exi", {31'd0, exi}, 32'd1);
        swi    = 1'b1;
        pc_epc = 32'h4010;
        tick();
        swi    = 1'b0;
        pc_epc = 32'h0;
        chk("t4_mepc", mepc, 32'h4010);
        chk("t4_mie_off", {31'd0, mie}, 32'd0);
        cfg_read(3'd0, rd);
        chk("t4_status", rd, 32'h0);
        cfg_read(3'd2, rd);
        chk("t4_pending", rd, 32'h01);
        chk("t4_exi_kept", {31'd0, exi}, 32'd1);
        irq_in = 8'h00;
        tick();

        // Vectored mvec via SWSET on edge source 4 (code 5)
        cfg_write(3'd1, 32'h10);
        cfg_write(3'd3, 32'h10);
        cfg_write(3'd6, 32'h10);
        tick();
        chk("t6_exi", {31'd0, exi}, 32'd1);
        chk("t6_code", {27'd0, exi_code}, 32'd5);
        chk("t6_mvec", mvec, exp_vec);
        cfg_read(3'd6, rd);
        chk("t6_swset_rd", rd, 32'h0);

        // Edge coincident with W1C clear: edge wins
        irq_in = 8'h10;
        cfg_write(3'd2, 32'h10);
        cfg_read(3'd2, rd);
        chk("edge_vs_clr", rd, 32'h10);
        irq_in = 8'h00;
        cfg_write(3'd2, 32'h10);
        tick();
        chk("clr_exi_off", {31'd0, exi}, 32'd0);
        chk("clr_mvec", mvec, 32'h100);

        // Register masking and reserved slot
        cfg_write(3'd4, 32'h0000_0203);
        cfg_read(3'd4, rd);
        chk("mvec_mask", rd, 32'h200);
        chk("mvec_out", mvec, 32'h200);
        cfg_write(3'd7, 32'hFFFF_FFFF);
        cfg_read(3'd7, rd);
        chk("rsvd_rd", rd, 32'h0);
        cfg_write(3'd1, 32'hFFFF_FFFF);
        cfg_read(3'd1, rd);
        chk("enable_width", rd, 32'hFF);
        cfg_write(3'd5, 32'h1234_5678);
        chk("mepc_wr", mepc, 32'h1234_5678);

        // Reset in the middle of an access drops the ack
        cfg_bus.cfg_req = 1'b1;
        cfg_bus.cfg_rwn = 1'b1;
        cfg_bus.cfg_adr = 3'd4;
        sys_rst = 1'b1;
        tick();
        cfg_bus.cfg_req = 1'b0;
        chk("rst_mid_ack", {31'd0, cfg_bus.cfg_ack}, 32'd0);
        chk("rst_mid_rdata", cfg_bus.cfg_rdata, 32'd0);
        chk("rst_mid_mvec", mvec, 32'h100);
        chk("rst_mid_mepc", mepc, 32'd0);
        sys_rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mp_intc.md
Name: mp_intc

Overview:
- Machine-level interrupt controller sitting directly upstream of the core's branch unit.
- Collects up to NIRQ external request lines plus the core's software-interrupt pulse.
- Supplies the core with mie, exi, exi_code, mvec and mepc; consumes swi, mie_set and pc_epc.
- Exposes a small single-cycle config-register port for enables, pending, trigger mode, vector and EPC.

Parameters:
- NIRQ, 8, number of external sources; legal range 1..31.
- MVEC_RST, 32'h0000_0100, reset value of the vector register.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  reset; synchronous, active-high.
- irq_in  input  NIRQ  external requests, already synchronous to sys_clk.
- swi  input  1  ecall pulse from the core.
- mie_set  input  1  wfi/mret pulse from the core; re-enables interrupts.
- pc_epc  input  32  PC to save on interrupt/exception entry.
- mie  output  1  global interrupt enable.
- exi  output  1  external interrupt request to the core.
- exi_code  output  5  cause of the current exi; 1..NIRQ.
- mvec  output  32  interrupt vector.
- mepc  output  32  saved exception PC.
- cfg_req  input  1  config access request.
- cfg_rwn  input  1  1 = read, 0 = write.
- cfg_adr  input  3  register index.
- cfg_wdata  input  32  write data.
- cfg_ack  output  1  one-cycle access completion.
- cfg_rdata  output  32  read data; valid while cfg_ack = 1.

Behaviour:
- Reset (sync, sys_rst = 1): mie = 0, exi = 0, exi_code = 0, cause = 0, ENABLE = 0, PENDING = 0, EDGE = 0, mepc = 0, mvec = MVEC_RST, cfg_ack = 0, cfg_rdata = 0, irq_d = 0. Reset mid-access drops the access; no ack is issued.
- Source tracking, per source i:
  - EDGE[i] = 1: a rising edge (irq_in[i] & ~irq_d[i]) sets PENDING[i]. The bit is cleared by a W1C write or by being taken.
  - EDGE[i] = 0: PENDING[i] = irq_in[i] each cycle; W1C and take have no effect.
  - An edge arriving in the same cycle as a clear wins (bit stays set).
- Arbitration: req = PENDING & ENABLE. Registered outputs: exi <= |req; exi_code <= index of the lowest set bit + 1. Latency from irq_in to exi is 2 cycles for edge sources and 1 cycle for level sources.
- Take rules, evaluated each cycle in this priority order:
  1. swi = 1: mepc <= pc_epc; mie <= 0; cause <= 0. Any exi is not taken this cycle; its pending state is retained.
  2. exi = 1 and mie = 1: mepc <= pc_epc; mie <= 0; cause <= exi_code; the edge pending bit for exi_code is cleared.
  3. mie_set = 1: mie <= 1. An exi present in the same cycle is not taken, because mie was 0; it is taken on the following cycle.
- A cfg write to STATUS or MEPC in the same cycle as a take loses to the take.
- Config registers (cfg_adr):
  - 0 STATUS: bit0 mie, bits 12:8 cause, read/write.
  - 1 ENABLE: bits NIRQ-1:0.
  - 2 PENDING: W1C.
  - 3 EDGE.
  - 4 MVEC: bits 1:0 forced to 0.
  - 5 MEPC.
  - 6 SWSET: write-1 sets the edge pending bits; reads as 0.
  - 7: reserved; reads 0, writes ignored.
- Unused upper bits read 0.
- Config handshake: on cfg_req, the register is written in that cycle (for writes), and cfg_ack = 1 with cfg_rdata valid on the next cycle.
  - cfg_req held high gives back-to-back accesses, one per cycle, each acked one cycle later.
  - cfg_rdata = 0 for writes.

Optional Feature:
- Macro: MP_INTC_VECTORED_EN.
- Defined: mvec output = MVEC + {exi_code, 2'b00} while exi = 1, else MVEC. swi uses MVEC unmodified.
- Undefined: mvec output = MVEC always (single shared vector).

Test Plan:
- Reset, then read all 8 registers -> MVEC = 0x100, all others read 0; mie = 0, exi = 0.
- ENABLE = 0x0C, EDGE = 0x0C, STATUS = 1, pulse irq_in[3] and irq_in[2] in the same cycle with pc_epc = 0x2000 -> two cycles later exi = 1, exi_code = 3. Next cycle mie = 0, mepc = 0x2000, cause = 3, PENDING = 0x08. mie_set pulse -> code 4 is taken.
- Level source 0 enabled, irq_in[0] held high, write 1 to PENDING bit0 -> PENDING bit0 stays 1 and exi stays 1. Drop irq_in[0] -> exi = 0 one cycle later.
- swi with exi = 1, mie = 1 and pc_epc = 0x4010 in the same cycle -> cause = 0, mepc = 0x4010, mie = 0, exi source still pending.
- mie_set in the same cycle as exi with mie = 0 -> no take that cycle; take the next cycle with mepc = the pc_epc of that next cycle.
- With MP_INTC_VECTORED_EN defined, MVEC = 0x100, source 4 pending -> mvec = 0x114. Built without the macro -> mvec = 0x100.
